// File: rtl/vc_pkg.sv
// vc_pkg: shared types for the victim cache controller.
package vc_pkg;
    typedef enum logic {VC_PROBE, VC_INSERT} vc_op_e;
    typedef enum logic [3:0] {IDLE, LKUP, LKCHK, INVAL, VRD, VCHK, WB, WR, DRTY, RESP} vc_state_e;
    localparam int VC_PERF_CNT_W = 16;
endpackage

// File: rtl/vc_victim_sel.sv
// vc_victim_sel: picks the lowest invalid way, else the round-robin way.
module vc_victim_sel #(
    parameter int NUM_WAYS = 4,
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] shadow_valid,
    input  logic [WAY_W-1:0]    rr_ptr,
    output logic [WAY_W-1:0]    victim,
    output logic                rr_advance
);
    always_comb begin
        victim = rr_ptr;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!shadow_valid[i]) victim = WAY_W'(i);
    end
    assign rr_advance = &shadow_valid;
endmodule

// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl: sequences tag_store commands for L1 probe/insert requests.
// Optional VC_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module victim_cache_ctrl
    import vc_pkg::*;
#(
    parameter int TAG_WIDTH = 4,
    parameter int NUM_WAYS = 4,
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 req_dirty,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [WAY_W-1:0]     resp_way,
    output logic                 ts_lookup_en,
    output logic                 ts_read_en,
    output logic                 ts_write_en,
    output logic                 ts_valid_clear,
    output logic                 ts_dirty_set,
    output logic                 ts_dirty_clear,
    output logic [TAG_WIDTH-1:0] ts_tag,
    output logic [WAY_W-1:0]     ts_way,
    input  logic                 ts_hit,
    input  logic [WAY_W-1:0]     ts_hit_way,
    input  logic                 ts_dirty_read,
    input  logic [TAG_WIDTH-1:0] ts_tag_read,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag
`ifdef VC_PERF_CNT_EN
    ,
    output logic [VC_PERF_CNT_W-1:0] hit_cnt,
    output logic [VC_PERF_CNT_W-1:0] miss_cnt,
    output logic [VC_PERF_CNT_W-1:0] wb_cnt
`endif
);
    vc_state_e state, next;
    vc_op_e op_q;
    logic [TAG_WIDTH-1:0] tag_q, wb_tag_q;
    logic dirty_q, hit_q;
    logic [WAY_W-1:0] way_q, rr_ptr, victim;
    logic [NUM_WAYS-1:0] shadow_valid;
    logic rr_advance;

    vc_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_sel (
        .shadow_valid(shadow_valid),
        .rr_ptr(rr_ptr),
        .victim(victim),
        .rr_advance(rr_advance)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = IDLE;
        case (state)
            IDLE:  next = req_valid ? LKUP : IDLE;
            LKUP:  next = LKCHK;
            LKCHK: next = op_q == VC_PROBE ? (ts_hit ? INVAL : RESP) :
                          (ts_hit || !rr_advance) ? WR : VRD;
            INVAL: next = RESP;
            VRD:   next = VCHK;
            VCHK:  next = ts_dirty_read ? WB : WR;
            WB:    next = wb_ready ? WR : WB;
            WR:    next = DRTY;
            DRTY:  next = RESP;
            RESP:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = state == IDLE;
        resp_valid     = state == RESP;
        ts_lookup_en   = state == LKUP;
        ts_read_en     = state == VRD;
        ts_write_en    = state == WR;
        ts_valid_clear = state == INVAL;
        // a hit keeps its existing dirty bit; only a fresh clean line needs clearing
        ts_dirty_set   = state == DRTY && dirty_q;
        ts_dirty_clear = state == DRTY && !dirty_q && !hit_q;
        wb_valid       = state == WB;
    end

    assign ts_tag   = tag_q;
    assign ts_way   = way_q;
    assign resp_hit = hit_q;
    assign resp_way = way_q;
    assign wb_tag   = wb_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= VC_PROBE;
            tag_q        <= '0;
            dirty_q      <= 1'b0;
            hit_q        <= 1'b0;
            way_q        <= '0;
            wb_tag_q     <= '0;
            shadow_valid <= '0;
            rr_ptr       <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q    <= vc_op_e'(req_op);
                tag_q   <= req_tag;
                dirty_q <= req_dirty;
            end
            if (state == LKCHK) begin
                hit_q <= ts_hit;
                if (ts_hit) way_q <= ts_hit_way;
                else if (op_q == VC_INSERT) begin
                    way_q <= victim;
                    if (rr_advance) rr_ptr <= rr_ptr + WAY_W'(1);
                end
            end
            if (state == VCHK) wb_tag_q <= ts_tag_read;
            if (state == WR) shadow_valid[way_q] <= 1'b1;
            if (state == INVAL) shadow_valid[way_q] <= 1'b0;
        end
    end

`ifdef VC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (state == RESP && op_q == VC_PROBE && hit_q && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (state == RESP && op_q == VC_PROBE && !hit_q && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            if (wb_valid && wb_ready && wb_cnt != '1) wb_cnt <= wb_cnt + 1'b1;
        end
    end
`endif
endmodule
